msg_key_loader: RTL and testbench

- Assembles the 128-bit message and 128-bit key from a byte stream (UART receiver output) and presents them to the segment-select/display stage.
- Frame format: sync byte, then 16 message bytes, then 16 key bytes.
- Downstream outputs update atomically, only when a complete frame has been received, so the display never shows a partial value.

---
 rtl/msg_key_loader.sv | 122 ++++++++++++
 tb/tb_msg_key_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/msg_key_loader.sv
// Byte-stream loader: sync byte, 16 msg bytes, 16 key bytes.
// msg/key are committed atomically once the whole frame has arrived.
module msg_key_loader #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 1000000,
  parameter int         CW          = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic [127:0] msg,
  output logic [127:0] key,
  output logic         load_done,
  output logic         load_err,
  output logic         busy,
  output logic [7:0]   frame_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_MSG,
    LOAD_KEY,
    COMMIT
  } state_t;

  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT_CYC - 1);

  state_t        state, state_n;
  logic [3:0]    idx, idx_n;
  logic [CW-1:0] tcnt, tcnt_n;
  logic [127:0]  msg_sh, key_sh;
  logic          acc;
  logic          wr_msg, wr_key;
  logic          done_n, err_n;
  logic [6:0]    base;

  assign in_ready = (state != COMMIT);
  assign busy     = (state != IDLE);
  assign acc      = in_valid && in_ready;
  // MSB-first placement: idx 0 -> bit 127, idx 15 -> bit 7
  assign base     = {~idx, 3'b111};

  always_comb begin
    state_n = state;
    idx_n   = idx;
    tcnt_n  = '0;
    wr_msg  = 1'b0;
    wr_key  = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (acc && in_data == SYNC_BYTE) begin
          state_n = LOAD_MSG;
          idx_n   = '0;
        end
      end
      LOAD_MSG: begin
        if (acc) begin
          wr_msg = 1'b1;
          idx_n  = idx + 4'd1;
          if (idx == 4'd15) state_n = LOAD_KEY;
        end else if (tcnt == TLIM) begin
          state_n = IDLE;
          idx_n   = '0;
          err_n   = 1'b1;
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      LOAD_KEY: begin
        if (acc) begin
          wr_key = 1'b1;
          idx_n  = idx + 4'd1;
          if (idx == 4'd15) state_n = COMMIT;
        end else if (tcnt == TLIM) begin
          state_n = IDLE;
          idx_n   = '0;
          err_n   = 1'b1;
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      COMMIT: begin
        state_n = IDLE;
        idx_n   = '0;
        done_n  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      tcnt      <= '0;
      msg_sh    <= '0;
      key_sh    <= '0;
      msg       <= '0;
      key       <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      tcnt      <= tcnt_n;
      load_done <= done_n;
      load_err  <= err_n;
      if (wr_msg) msg_sh[base -: 8] <= in_data;
      if (wr_key) key_sh[base -: 8] <= in_data;
      if (state == COMMIT) begin
        msg       <= msg_sh;
        key       <= key_sh;
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_msg_key_loader.sv
// Directed bench for msg_key_loader with a frame-level reference model
// checked every cycle, plus literal checks on the committed values.
module tb_msg_key_loader;

  localparam int T = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic [127:0] msg, key;
  logic         load_done, load_err, busy;
  logic [7:0]   frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  msg_key_loader #(
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYC(T),
    .CW(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .msg(msg),
    .key(key),
    .load_done(load_done),
    .load_err(load_err),
    .busy(busy),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: pos = -1 idle, 0..31 payload byte, 32 commit
  int           m_pos;
  int           m_idle;
  logic [127:0] m_msh, m_ksh, m_msg, m_key;
  logic         m_done, m_err;
  logic [7:0]   m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pos = -1; m_idle = 0;
      m_msh = '0; m_ksh = '0; m_msg = '0; m_key = '0;
      m_done = 0; m_err = 0; m_cnt = '0;
    end else begin
      m_done = 0;
      m_err  = 0;
      if (m_pos == 32) begin
        m_msg = m_msh;
        m_key = m_ksh;
        m_done = 1;
        m_cnt = m_cnt + 8'd1;
        m_pos = -1;
      end else if (m_pos == -1) begin
        if (in_valid && in_data == 8'hA5) begin
          m_pos = 0;
          m_idle = 0;
        end
      end else if (in_valid) begin
        if (m_pos < 16) m_msh[127 - 8*m_pos -: 8] = in_data;
        else m_ksh[127 - 8*(m_pos-16) -: 8] = in_data;
        m_pos++;
        m_idle = 0;
      end else begin
        m_idle++;
        if (m_idle == T) begin
          m_err = 1;
          m_pos = -1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("in_ready", 128'(in_ready), 128'(m_pos != 32));
    check("busy", 128'(busy), 128'(m_pos != -1));
    check("msg", msg, m_msg);
    check("key", key, m_key);
    check("load_done", 128'(load_done), 128'(m_done));
    check("load_err", 128'(load_err), 128'(m_err));
    check("frame_cnt", 128'(frame_cnt), 128'(m_cnt));
  end

  task automatic send(input logic [7:0] d, input int gap);
    bit ok = 0;
    repeat (gap) begin
      in_valid = 0;
      @(posedge clk); #1;
    end
    in_valid = 1;
    in_data  = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 0;
    if (!ok) check("send_timeout", 128'(0), 128'(1));
  endtask

  task automatic send_frame(input logic [127:0] mv,
                            input logic [127:0] kv,
                            input int maxgap);
    logic [127:0] t;
    send(8'hA5, maxgap ? $urandom_range(0, maxgap) : 0);
    t = mv;
    for (int i = 0; i < 16; i++)
      send(t[127 - 8*i -: 8], maxgap ? $urandom_range(0, maxgap) : 0);
    t = kv;
    for (int i = 0; i < 16; i++)
      send(t[127 - 8*i -: 8], maxgap ? $urandom_range(0, maxgap) : 0);
  endtask

  task automatic do_reset;
    rst = 1;
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
  endtask

  localparam logic [127:0] M1 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] K1 = 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF;
  localparam logic [127:0] M2 = 128'hA5A5123456789ABCDEF0A51122334455;
  localparam logic [127:0] K2 = 128'h0123A5A5A5A5CAFEBABEDEADBEEFA5A5;

  initial begin
    rst = 1; in_valid = 0; in_data = '0;
    #1;
    check("rst_msg", msg, '0);
    check("rst_frame_cnt", 128'(frame_cnt), '0);
    do_reset();
    check("rst_in_ready", 128'(in_ready), 128'(1));

    // gapless frame
    send_frame(M1, K1, 0);
    check("commit_ready", 128'(in_ready), 128'(0));
    check("pre_done", 128'(load_done), 128'(0));
    @(posedge clk); #1;
    check("lit_done", 128'(load_done), 128'(1));
    check("lit_msg1", msg, M1);
    check("lit_key1", key, K1);
    check("lit_cnt1", 128'(frame_cnt), 128'(1));

    // garbage then frame with sync values in the payload
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
    send_frame(M2, K2, 0);
    @(posedge clk); #1;
    check("lit_msg2", msg, M2);
    check("lit_key2", key, K2);

    // timeout after 5 message bytes
    send(8'hA5, 0);
    for (int i = 0; i < 5; i++) send(8'(i + 8'h40), 0);
    repeat (T) @(posedge clk);
    #1;
    check("lit_err", 128'(load_err), 128'(1));
    check("lit_err_busy", 128'(busy), 128'(0));
    check("lit_err_msg", msg, M2);
    @(posedge clk); #1;
    check("lit_err_pulse", 128'(load_err), 128'(0));
    send_frame(M1, K1, 0);
    @(posedge clk); #1;
    check("lit_msg3", msg, M1);

    // gaps shorter than the timeout
    send_frame(K2, M2, 6);
    @(posedge clk); #1;
    check("lit_gap_msg", msg, K2);
    check("lit_gap_key", key, M2);
    check("lit_gap_cnt", 128'(frame_cnt), 128'(4));

    // reset during LOAD_KEY
    send(8'hA5, 0);
    for (int i = 0; i < 20; i++) send(8'(i), 0);
    rst = 1;
    #1;
    check("midrst_msg", msg, '0);
    check("midrst_key", key, '0);
    check("midrst_cnt", 128'(frame_cnt), '0);
    @(posedge clk); #1;
    rst = 0;
    check("midrst_ready", 128'(in_ready), 128'(1));
    send_frame(M2, K1, 0);
    @(posedge clk); #1;
    check("lit_after_rst", msg, M2);

    // back-to-back frames, sync held through COMMIT
    do_reset();
    send_frame(M1, K2, 0);
    in_valid = 1;
    in_data  = 8'hA5;
    check("b2b_commit_ready", 128'(in_ready), 128'(0));
    @(posedge clk); #1;
    check("b2b_idle_ready", 128'(in_ready), 128'(1));
    check("b2b_idle_busy", 128'(busy), 128'(0));
    @(posedge clk); #1;
    in_valid = 0;
    check("b2b_sync_taken", 128'(busy), 128'(1));
    for (int i = 0; i < 16; i++) send(M2[127 - 8*i -: 8], 0);
    for (int i = 0; i < 16; i++) send(K1[127 - 8*i -: 8], 0);
    @(posedge clk); #1;
    check("b2b_msg", msg, M2);
    check("b2b_key", key, K1);
    check("b2b_cnt", 128'(frame_cnt), 128'(2));

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
